// File: rtl/culsans_sim_ctrl.sv
// culsans_sim_ctrl
//   Simulation controller for multi-hart Culsans top-levels. Holds the cores in
//   reset for a fixed number of cycles, derives the RTC tick from the system
//   clock, latches per-hart exit words and produces a sticky done/pass verdict.
//   An optional watchdog ends a run that never exits.
//
//   Ports
//     clk_i      system clock
//     rst        asynchronous active-low reset
//     exit_i     per-hart exit words, hart h at [h*ExitWidth +: ExitWidth]
//                (bit0 = done, upper bits = return code)
//     rst_no     core reset, active-low, registered
//     rtc_o      real-time clock, 50% duty, period RtcDiv clk cycles
//     done_o     run finished (sticky until rst)
//     pass_o     verdict, meaningful while done_o is high
//     timeout_o  watchdog expired (sticky)
//     code_o     first nonzero latched return code (lowest hart), else 0
//     hart_o     hart index of code_o, NumHarts when no nonzero code
//     exited_o   per-hart latched-exit flags
//     cycles_o   clk cycles spent in RUN, saturating
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_RESET | core reset held low, counting ResetCycles edges
//   S_RUN   | cores running, exits latched, cycle counter and watchdog active
//   S_DONE  | verdict frozen until rst
`timescale 1ns/1ps

module culsans_sim_ctrl #(
   parameter int unsigned NumHarts      = 2,
   parameter int unsigned ExitWidth     = 32,
   parameter int unsigned ResetCycles   = 4,
   parameter int unsigned RtcDiv        = 3052,
   parameter int unsigned TimeoutCycles = 0,
   parameter bit          WaitAll       = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          rst,
   input  logic [NumHarts*ExitWidth-1:0] exit_i,
   output logic                          rst_no,
   output logic                          rtc_o,
   output logic                          done_o,
   output logic                          pass_o,
   output logic                          timeout_o,
   output logic [ExitWidth-2:0]          code_o,
   output logic [$clog2(NumHarts):0]     hart_o,
   output logic [NumHarts-1:0]           exited_o,
   output logic [63:0]                   cycles_o
);

   localparam int unsigned HartW   = $clog2(NumHarts) + 1;
   localparam int unsigned RstCntW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
   localparam int unsigned RtcHalf = RtcDiv / 2;
   localparam int unsigned RtcCntW = (RtcHalf > 1) ? $clog2(RtcHalf) : 1;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_RUN   = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t               state;
   logic [RstCntW-1:0]   rst_cnt;
   logic [RtcCntW-1:0]   rtc_cnt;
   logic [ExitWidth-2:0] code_q [NumHarts];

   logic [NumHarts-1:0]  exit_vld;
   logic [ExitWidth-2:0] exit_code [NumHarts];
   logic [NumHarts-1:0]  new_exit;
   logic [NumHarts-1:0]  exited_next;
   logic                 exit_done;
   logic                 wdog_hit;
   logic [63:0]          cycles_inc;
   logic                 any_bad;

   always_comb begin
      exit_vld = '0;
      for (int h = 0; h < NumHarts; h++) begin
         exit_vld[h]  = exit_i[h*ExitWidth];
         exit_code[h] = exit_i[h*ExitWidth+1 +: ExitWidth-1];
      end
      // only the first exit of each hart is captured
      new_exit    = exit_vld & ~exited_o;
      exited_next = exited_o | new_exit;
      exit_done   = WaitAll ? (&exited_next) : (|exited_next);
      wdog_hit    = (TimeoutCycles != 0) && (cycles_o == (64'(TimeoutCycles) - 64'd1));
      cycles_inc  = (&cycles_o) ? cycles_o : cycles_o + 64'd1;
   end

   // Descending scan so the lowest failing hart ends up reported.
   always_comb begin
      code_o  = '0;
      hart_o  = HartW'(NumHarts);
      any_bad = 1'b0;
      for (int h = NumHarts - 1; h >= 0; h--) begin
         if (exited_o[h] && (code_q[h] != '0)) begin
            code_o  = code_q[h];
            hart_o  = HartW'(h);
            any_bad = 1'b1;
         end
      end
      pass_o = done_o && !timeout_o && !any_bad;
   end

   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         state     <= S_RESET;
         rst_cnt   <= RstCntW'(ResetCycles - 1);
         rst_no    <= 1'b0;
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
         exited_o  <= '0;
         cycles_o  <= '0;
         for (int h = 0; h < NumHarts; h++) begin
            code_q[h] <= '0;
         end
      end else begin
         case (state)
            S_RESET: begin
               if (rst_cnt == '0) begin
                  state  <= S_RUN;
                  rst_no <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt - 1'b1;
               end
            end
            S_RUN: begin
               cycles_o <= cycles_inc;
               exited_o <= exited_next;
               for (int h = 0; h < NumHarts; h++) begin
                  if (new_exit[h]) begin
                     code_q[h] <= exit_code[h];
                  end
               end
               // an exit completing on the watchdog edge takes priority
               if (exit_done) begin
                  state  <= S_DONE;
                  done_o <= 1'b1;
               end else if (wdog_hit) begin
                  state     <= S_DONE;
                  done_o    <= 1'b1;
                  timeout_o <= 1'b1;
               end
            end
            S_DONE: begin
            end
            default: begin
               state <= S_RESET;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         rtc_cnt <= RtcCntW'(RtcHalf - 1);
         rtc_o   <= 1'b0;
      end else if (rtc_cnt == '0) begin
         rtc_cnt <= RtcCntW'(RtcHalf - 1);
         rtc_o   <= ~rtc_o;
      end else begin
         rtc_cnt <= rtc_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_culsans_sim_ctrl.sv
`timescale 1ns/1ps

module tb_culsans_sim_ctrl;

   typedef struct packed {
      logic        pass;
      logic        timeout;
      logic [6:0]  code;
      logic [1:0]  hart;
      logic [1:0]  exited;
      logic [63:0] cycles;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic [15:0] exit_a, exit_b;
   logic        rst_no_a, rtc_a, done_a, pass_a, to_a;
   logic        rst_no_b, rtc_b, done_b, pass_b, to_b;
   logic [6:0]  code_a, code_b;
   logic [1:0]  hart_a, hart_b, exited_a, exited_b;
   logic [63:0] cyc_a, cyc_b;

   culsans_sim_ctrl #(
      .NumHarts(2), .ExitWidth(8), .ResetCycles(4), .RtcDiv(8),
      .TimeoutCycles(0), .WaitAll(1'b1)
   ) dut_a (
      .clk_i(clk), .rst(rst_a), .exit_i(exit_a), .rst_no(rst_no_a), .rtc_o(rtc_a),
      .done_o(done_a), .pass_o(pass_a), .timeout_o(to_a), .code_o(code_a),
      .hart_o(hart_a), .exited_o(exited_a), .cycles_o(cyc_a)
   );

   culsans_sim_ctrl #(
      .NumHarts(2), .ExitWidth(8), .ResetCycles(4), .RtcDiv(8),
      .TimeoutCycles(100), .WaitAll(1'b0)
   ) dut_b (
      .clk_i(clk), .rst(rst_b), .exit_i(exit_b), .rst_no(rst_no_b), .rtc_o(rtc_b),
      .done_o(done_b), .pass_o(pass_b), .timeout_o(to_b), .code_o(code_b),
      .hart_o(hart_b), .exited_o(exited_b), .cycles_o(cyc_b)
   );

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic p, input logic t, input logic [6:0] c,
                               input logic [1:0] h, input logic [1:0] x,
                               input logic [63:0] cy);
      exp_t e;
      e.pass = p; e.timeout = t; e.code = c; e.hart = h; e.exited = x; e.cycles = cy;
      return e;
   endfunction

   task automatic check_exp(input string t, input exp_t e, input logic p, input logic to,
                            input logic [6:0] c, input logic [1:0] h, input logic [1:0] x,
                            input logic [63:0] cy);
      chk({t, "_pass"},    64'(p),  64'(e.pass));
      chk({t, "_timeout"}, 64'(to), 64'(e.timeout));
      chk({t, "_code"},    64'(c),  64'(e.code));
      chk({t, "_hart"},    64'(h),  64'(e.hart));
      chk({t, "_exited"},  64'(x),  64'(e.exited));
      chk({t, "_cycles"},  cy,      e.cycles);
   endtask

   // Monitors: each rising edge of done is one DUT response, matched in order.
   logic prev_a = 1'b0, prev_b = 1'b0;
   exp_t ea, eb;

   always @(negedge clk) begin
      if (done_a && !prev_a) begin
         if (q_a.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_a_unexpected: done raised with nothing expected");
         end else begin
            ea = q_a.pop_front();
            check_exp("sb_a", ea, pass_a, to_a, code_a, hart_a, exited_a, cyc_a);
         end
      end
      prev_a = done_a;
   end

   always @(negedge clk) begin
      if (done_b && !prev_b) begin
         if (q_b.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_b_unexpected: done raised with nothing expected");
         end else begin
            eb = q_b.pop_front();
            check_exp("sb_b", eb, pass_b, to_b, code_b, hart_b, exited_b, cyc_b);
         end
      end
      prev_b = done_b;
   end

   task automatic reset_a();
      rst_a  = 1'b0;
      exit_a = '0;
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
   endtask

   task automatic reset_b();
      rst_b  = 1'b0;
      exit_b = '0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
   endtask

   task automatic wait_done_a(input int lim);
      int k = 0;
      while (!done_a && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (!done_a) begin
         n_cmp++; n_bad++;
         $display("FAIL a_done_wait: done_o=0 required 1 within %0d cycles", lim);
      end
      @(negedge clk);
      chk("a_drain", 64'(q_a.size()), 64'd0);
   endtask

   task automatic wait_done_b(input int lim);
      int k = 0;
      while (!done_b && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (!done_b) begin
         n_cmp++; n_bad++;
         $display("FAIL b_done_wait: done_o=0 required 1 within %0d cycles", lim);
      end
      @(negedge clk);
      chk("b_drain", 64'(q_b.size()), 64'd0);
   endtask

   task automatic chk_reset_a(input string t);
      chk({t, "_rst_no"}, 64'(rst_no_a), 64'd0);
      chk({t, "_rtc"},    64'(rtc_a),    64'd0);
      chk({t, "_done"},   64'(done_a),   64'd0);
      chk({t, "_pass"},   64'(pass_a),   64'd0);
      chk({t, "_to"},     64'(to_a),     64'd0);
      chk({t, "_code"},   64'(code_a),   64'd0);
      chk({t, "_hart"},   64'(hart_a),   64'd2);
      chk({t, "_exited"}, 64'(exited_a), 64'd0);
      chk({t, "_cycles"}, cyc_a,         64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; exit_a = '0; exit_b = '0;
      @(negedge clk);
      chk_reset_a("reset");

      // Reset sequencing, RTC waveform, exits held through RESET are ignored.
      reset_a();
      exit_a = 16'h0101;
      q_a.push_back(mk(1'b1, 1'b0, 7'd0, 2'd2, 2'b11, 64'd1));
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("t1_rst_no_%0d", k), 64'(rst_no_a), 64'(k >= 4));
         chk($sformatf("t1_rtc_%0d", k),    64'(rtc_a),    64'((k / 4) % 2));
         chk($sformatf("t1_done_%0d", k),   64'(done_a),   64'(k >= 5));
         chk($sformatf("t1_cycles_%0d", k), cyc_a,         (k >= 5) ? 64'd1 : 64'd0);
         if (k == 3) chk("t1_exit_ignored", 64'(exited_a), 64'd0);
      end
      wait_done_a(5);

      // Staggered clean exits, 1-cycle latency, DONE ignores later exit changes.
      reset_a();
      repeat (4) @(negedge clk);
      exit_a[7:0] = 8'h01;
      repeat (10) @(negedge clk);
      chk("t2_not_done", 64'(done_a),   64'd0);
      chk("t2_exited0",  64'(exited_a), 64'd1);
      exit_a[15:8] = 8'h01;
      q_a.push_back(mk(1'b1, 1'b0, 7'd0, 2'd2, 2'b11, 64'd11));
      @(negedge clk);
      chk("t2_latency", 64'(done_a), 64'd1);
      exit_a = 16'h0303;
      repeat (3) @(negedge clk);
      chk("t2_frozen_cycles", cyc_a,          64'd11);
      chk("t2_frozen_code",   64'(code_a),    64'd0);
      chk("t2_frozen_pass",   64'(pass_a),    64'd1);
      chk("t2_rst_no_done",   64'(rst_no_a),  64'd1);
      wait_done_a(2);

      // Simultaneous failing exits: lowest hart reported.
      reset_a();
      repeat (4) @(negedge clk);
      exit_a = 16'h0705;
      q_a.push_back(mk(1'b0, 1'b0, 7'd2, 2'd0, 2'b11, 64'd1));
      wait_done_a(5);

      // Exit word changing after latch does not alter the latched code.
      reset_a();
      repeat (4) @(negedge clk);
      exit_a = 16'h0001;
      repeat (2) @(negedge clk);
      exit_a = 16'h0009;
      repeat (2) @(negedge clk);
      exit_a = 16'h0109;
      q_a.push_back(mk(1'b1, 1'b0, 7'd0, 2'd2, 2'b11, 64'd5));
      wait_done_a(5);

      // Asynchronous reset mid-RUN, then the full sequence again.
      reset_a();
      repeat (4) @(negedge clk);
      exit_a = 16'h0003;
      repeat (3) @(negedge clk);
      chk("t5_run_exited", 64'(exited_a), 64'd1);
      chk("t5_run_code",   64'(code_a),   64'd1);
      chk("t5_run_hart",   64'(hart_a),   64'd0);
      chk("t5_run_cycles", cyc_a,         64'd3);
      #1 rst_a = 1'b0;
      #1 chk_reset_a("t5_async");
      exit_a = '0;
      @(negedge clk);
      rst_a = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_rerun_rst_no_lo", 64'(rst_no_a), 64'd0);
      @(negedge clk);
      chk("t5_rerun_rst_no_hi", 64'(rst_no_a), 64'd1);
      exit_a = 16'h0101;
      q_a.push_back(mk(1'b1, 1'b0, 7'd0, 2'd2, 2'b11, 64'd1));
      wait_done_a(5);

      // Watchdog with no exit.
      reset_b();
      q_b.push_back(mk(1'b0, 1'b1, 7'd0, 2'd2, 2'b00, 64'd100));
      repeat (103) @(negedge clk);
      chk("t4_pre_done",   64'(done_b), 64'd0);
      chk("t4_pre_cycles", cyc_b,       64'd99);
      wait_done_b(5);

      // Exit on the watchdog edge wins.
      reset_b();
      repeat (103) @(negedge clk);
      exit_b = 16'h0001;
      q_b.push_back(mk(1'b1, 1'b0, 7'd0, 2'd2, 2'b01, 64'd100));
      wait_done_b(5);

      // First-exit mode with a failing code on hart 1.
      reset_b();
      repeat (14) @(negedge clk);
      exit_b = 16'h0500;
      q_b.push_back(mk(1'b0, 1'b0, 7'd2, 2'd1, 2'b10, 64'd11));
      wait_done_b(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
